register_bank_mp: RTL and testbench
===================================

// Module: register_bank_mp
// PURPOSE
// - Parametrised successor of the core register bank: DEPTH x XLEN, NUM_RD async read ports, one sync write port.
// - Adds a post-reset clear sequencer and a per-register pending scoreboard for hazard detection.
// - Sits in the decode stage of the RISC-V core. Writeback drives the write port; decode drives issue and reads.
// PARAMETERS
// - XLEN    32  data width in bits
// - DEPTH   32  number of registers (power of 2, >=2). AW = $clog2(DEPTH) is a localparam.
// - NUM_RD  2   number of read ports (>=1)
// PORTS
// - clk                    in   1            rising-edge clock
// - rst                    in   1            synchronous, active-high reset
// - init_done              out  1            high once clear sequence finished
// - write_enable           in   1            write strobe
// - write_register_addr    in   AW           write address
// - write_data             in   XLEN         write data
// - read_register_addr     in   NUM_RD*AW    packed read addresses; port i = [i*AW +: AW]
// - read_data              out  NUM_RD*XLEN  packed read data, combinational
// - read_pending           out  NUM_RD       scoreboard bit of each read address
// - issue_valid            in   1            instruction with destination issued
// - issue_rd               in   AW           destination register of issued instruction
// BEHAVIOUR
// - Reset: reset is synchronous and active-high; single clock domain.
//   - Effect of rst=1 on the next edge: state<=CLEAR, clr_cnt<=0, pending<=0.
//   - During rst and CLEAR: init_done=0, read_data=0, read_pending=0.
// - FSM CLEAR:
//   - One register is zeroed per cycle: regs[clr_cnt]<=0, clr_cnt++.
//   - When clr_cnt==DEPTH-1, that register is zeroed and state goes to RUN.
//   - init_done rises exactly DEPTH cycles after the first edge with rst=0.
//   - write_enable and issue_valid are ignored in CLEAR.
//   - rst asserted mid-CLEAR or in RUN restarts the sequence from clr_cnt=0.
// - FSM RUN: state is terminal until rst.
// - Register 0:
//   - Always reads 0.
//   - Writes to address 0 are dropped.
//   - Never marked pending.
// - Write (RUN):
//   - Condition: write_enable && addr!=0.
//   - Effect: regs[addr]<=write_data at the edge and pending[addr] is cleared.
// - Issue (RUN):
//   - Condition: issue_valid && issue_rd!=0.
//   - Effect: pending[issue_rd]<=1.
//   - Issue and write to the same address in the same cycle: set wins, a new producer is in flight.
// - Read: read_data[i]=regs[raddr_i], combinational, zero latency; read_pending[i]=pending[raddr_i].
// - Arithmetic: no arithmetic on data. clr_cnt is AW bits wide with no wrap, because the FSM leaves CLEAR at DEPTH-1.
// CONFIGURATION
// - Macro: REGBANK_WRITE_BYPASS_EN.
// - Defined:
//   - Applies when a read address equals the write address in the same cycle, in RUN, with write_enable=1 and addr!=0.
//   - read_data returns write_data combinationally.
//   - read_pending is forced to 0 for that port, unless issue hits the same address in that cycle.
// - Undefined:
//   - Same-cycle reads return the old value.
//   - The new value and the cleared pending bit are visible from the next cycle.
// STRUCTURE
// - Package regfile_pkg:
//   - regfile_state_e {CLEAR, RUN}
//   - localparam ZERO_REG = '0
//   - default XLEN/DEPTH constants shared with decode
// - Sub-module regfile_scoreboard:
//   - DEPTH pending flops with set/clear priority and the rst clear.
//   - NUM_RD lookup ports, plus an optional bypass mask input.
// - The top holds the storage array, the clear FSM and the read muxes.
// TESTING
// - Stimulus is driven on negedge clk; checks are made before the next posedge.
// - T1 reset clear:
//   - Stimulus: rst for 2 cycles, then release.
//   - Required: init_done=0 for exactly 32 cycles, then 1.
//   - Required: all 32 registers read 0 and all pending bits are 0.
// - T2 write/read:
//   - Stimulus: write addr 5 with 6.
//   - Required: next cycle, ports 0 and 1 at addr 5 both return 6.
//   - Stimulus: write addr 0 with 0xDEAD.
//   - Required: a read of addr 0 returns 0.
// - T3 bypass:
//   - Stimulus: write addr 7 with 0x1234 while port 0 reads addr 7.
//   - Required, macro defined: same cycle reads 0x1234.
//   - Required, macro undefined: same cycle reads the old value, 0x1234 on the next cycle.
// - T4 scoreboard:
//   - Stimulus: issue rd=9.
//   - Required: read_pending for addr 9 =1 from the next cycle.
//   - Stimulus: write 9.
//   - Required: pending=0 the cycle after the write.
//   - Stimulus: issue 9 and write 9 in the same cycle.
//   - Required: pending stays 1.
// - T5 reset mid-operation:
//   - Stimulus: write 3 with 0xAA, then assert rst at clr_cnt=10 of a second clear.
//   - Required: the sequence restarts at 0 and init_done arrives 32 cycles after release.
//   - Required: addr 3 reads 0.
// - T6 CLEAR gating:
//   - Stimulus: write_enable and issue_valid held high during CLEAR.
//   - Required: no register changes and no pending bits are set.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file types and defaults for decode and the register bank.
// Exports: regfile_state_e {CLEAR, RUN}, ZERO_REG, default XLEN/DEPTH/NUM_RD.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } regfile_state_e;

   localparam int ZERO_REG   = 0;

   localparam int XLEN_DEF   = 32;
   localparam int DEPTH_DEF  = 32;
   localparam int NUM_RD_DEF = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending flags: set on issue, cleared on writeback.
// Ports: clk, rst, set_en/set_addr, clr_en/clr_addr,
//   lookup_addr (packed, NUM_RD*AW), bypass_mask, lookup_pending.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int DEPTH  = DEPTH_DEF,
   parameter  int NUM_RD = NUM_RD_DEF,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 set_en,
   input  logic [AW-1:0]        set_addr,
   input  logic                 clr_en,
   input  logic [AW-1:0]        clr_addr,
   input  logic [NUM_RD*AW-1:0] lookup_addr,
   input  logic [NUM_RD-1:0]    bypass_mask,
   output logic [NUM_RD-1:0]    lookup_pending
);

   logic [DEPTH-1:0] pending;

   // Set is applied after clear so a same-cycle issue keeps the
   // register marked: the new producer is still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         if (clr_en) pending[clr_addr] <= 1'b0;
         if (set_en) pending[set_addr] <= 1'b1;
      end
   end

   always_comb begin
      lookup_pending = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         lookup_pending[i] = pending[lookup_addr[i*AW +: AW]]
                           & ~bypass_mask[i];
      end
   end

endmodule

// File: rtl/register_bank_mp.sv
// Multi-port register bank: DEPTH x XLEN storage, NUM_RD async reads,
// one sync write, post-reset clear sequencer and pending scoreboard.
// Ports: clk, rst (sync, active-high), init_done, write_enable,
//   write_register_addr, write_data, read_register_addr (packed),
//   read_data (packed), read_pending, issue_valid, issue_rd.
// Option: define REGBANK_WRITE_BYPASS_EN to forward same-cycle writes.
module register_bank_mp
   import regfile_pkg::*;
#(
   parameter  int XLEN   = XLEN_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   parameter  int NUM_RD = NUM_RD_DEF,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   init_done,
   input  logic                   write_enable,
   input  logic [AW-1:0]          write_register_addr,
   input  logic [XLEN-1:0]        write_data,
   input  logic [NUM_RD*AW-1:0]   read_register_addr,
   output logic [NUM_RD*XLEN-1:0] read_data,
   output logic [NUM_RD-1:0]      read_pending,
   input  logic                   issue_valid,
   input  logic [AW-1:0]          issue_rd
);

   localparam logic [AW-1:0] ZR   = AW'(ZERO_REG);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   regfile_state_e    state;
   regfile_state_e    state_nx;
   logic [AW-1:0]     clr_cnt;
   logic [AW-1:0]     clr_cnt_nx;

   logic              run;
   logic              clr_we;
   logic              wr_fire;
   logic              iss_fire;

   logic [XLEN-1:0]   regs [DEPTH];
   logic [AW-1:0]     raddr [NUM_RD];
   logic [NUM_RD-1:0] byp_mask;
   logic [NUM_RD-1:0] sb_pending;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nx;
         clr_cnt <= clr_cnt_nx;
      end
   end

   // Next state: walk clr_cnt to DEPTH-1, then stay in RUN.
   // The counter parks at DEPTH-1, so it never wraps.
   always_comb begin
      state_nx   = state;
      clr_cnt_nx = clr_cnt;
      unique case (state)
         CLEAR: begin
            if (clr_cnt == LAST) state_nx   = RUN;
            else                 clr_cnt_nx = clr_cnt + 1'b1;
         end
         RUN: state_nx = RUN;
      endcase
   end

   // Outputs/strobes: rst masks everything combinationally so the
   // bank looks empty in the reset cycle even if state is still RUN.
   always_comb begin
      run       = (state == RUN) && !rst;
      clr_we    = (state == CLEAR) && !rst;
      init_done = run;
      wr_fire   = run && write_enable && (write_register_addr != ZR);
      iss_fire  = run && issue_valid && (issue_rd != ZR);
   end

   // Storage: the clear sequencer owns the write port in CLEAR.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         regs[clr_cnt] <= '0;
      end else if (wr_fire) begin
         regs[write_register_addr] <= write_data;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         raddr[i] = read_register_addr[i*AW +: AW];
      end
   end

   // Read muxes
   always_comb begin
      read_data = '0;
      byp_mask  = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (run && raddr[i] != ZR) begin
            read_data[i*XLEN +: XLEN] = regs[raddr[i]];
         end
`ifdef REGBANK_WRITE_BYPASS_EN
         // Forwarded value is final unless a new producer issues
         // to the same register in this cycle.
         if (wr_fire && raddr[i] == write_register_addr) begin
            read_data[i*XLEN +: XLEN] = write_data;
            byp_mask[i] = !(iss_fire && issue_rd == write_register_addr);
         end
`endif
      end
   end

   regfile_scoreboard #(
      .DEPTH  (DEPTH),
      .NUM_RD (NUM_RD)
   ) u_sb (
      .clk            (clk),
      .rst            (rst),
      .set_en         (iss_fire),
      .set_addr       (issue_rd),
      .clr_en         (wr_fire),
      .clr_addr       (write_register_addr),
      .lookup_addr    (read_register_addr),
      .bypass_mask    (byp_mask),
      .lookup_pending (sb_pending)
   );

   assign read_pending = sb_pending & {NUM_RD{run}};

endmodule

// File: tb/tb_register_bank_mp.sv
// Scoreboard bench for register_bank_mp: directed and random traffic
// checked against a behavioural model of the bank.
module tb_register_bank_mp;

   localparam int XLEN   = 32;
   localparam int DEPTH  = 32;
   localparam int NUM_RD = 2;
   localparam int AW     = 5;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   init_done;
   logic                   write_enable;
   logic [AW-1:0]          write_register_addr;
   logic [XLEN-1:0]        write_data;
   logic [NUM_RD*AW-1:0]   read_register_addr;
   logic [NUM_RD*XLEN-1:0] read_data;
   logic [NUM_RD-1:0]      read_pending;
   logic                   issue_valid;
   logic [AW-1:0]          issue_rd;

   always #5 clk = ~clk;

   register_bank_mp #(
      .XLEN (XLEN), .DEPTH (DEPTH), .NUM_RD (NUM_RD)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .init_done           (init_done),
      .write_enable        (write_enable),
      .write_register_addr (write_register_addr),
      .write_data          (write_data),
      .read_register_addr  (read_register_addr),
      .read_data           (read_data),
      .read_pending        (read_pending),
      .issue_valid         (issue_valid),
      .issue_rd            (issue_rd)
   );

   typedef struct packed {
      int                          cyc;
      logic [NUM_RD-1:0][XLEN-1:0] data;
      logic [NUM_RD-1:0]           pend;
      logic                        done;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Reference model: register contents, in-flight set, and
   // number of post-reset cycles still needed before the bank is usable.
   logic [XLEN-1:0] m_reg  [DEPTH];
   bit              m_pend [DEPTH];
   bit              m_busy = 1'b1;
   int              m_left = DEPTH;

   task automatic step(input bit r, input bit we, input int wa,
                       input logic [XLEN-1:0] wd, input bit iv,
                       input int ir, input int ra0, input int ra1);
      exp_t e;
      int   ra [NUM_RD];
      bit   run;
      @(negedge clk);
      #1;
      rst                 = r;
      write_enable        = we;
      write_register_addr = AW'(wa);
      write_data          = wd;
      issue_valid         = iv;
      issue_rd            = AW'(ir);
      read_register_addr  = {AW'(ra1), AW'(ra0)};
      ra[0] = ra0;
      ra[1] = ra1;
      run   = !m_busy && !r;
      e     = '0;
      e.cyc  = cyc;
      e.done = run;
      for (int p = 0; p < NUM_RD; p++) begin
         if (run) begin
            e.data[p] = (ra[p] == 0) ? '0 : m_reg[ra[p]];
            e.pend[p] = m_pend[ra[p]];
`ifdef REGBANK_WRITE_BYPASS_EN
            if (we && wa != 0 && ra[p] == wa) begin
               e.data[p] = wd;
               if (!(iv && ir == wa)) e.pend[p] = 1'b0;
            end
`endif
         end
      end
      q.push_back(e);
      // effect of the coming edge
      if (r) begin
         m_busy = 1'b1;
         m_left = DEPTH;
         foreach (m_pend[k]) m_pend[k] = 1'b0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            foreach (m_reg[k]) m_reg[k] = '0;
         end
      end else begin
         if (we && wa != 0) begin
            m_reg[wa]  = wd;
            m_pend[wa] = 1'b0;
         end
         if (iv && ir != 0) m_pend[ir] = 1'b1;
      end
      cyc++;
   endtask

   task automatic idle(input int ra0, input int ra1);
      step(0, 0, 0, '0, 0, 0, ra0, ra1);
   endtask

   // Monitor: compare each queued expectation with the settled outputs.
   always @(negedge clk) begin : mon
      exp_t e;
      #3;
      while (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (init_done !== e.done) begin
            errors++;
            $display("FAIL init_done cyc %0d got %b exp %b",
                     e.cyc, init_done, e.done);
         end
         for (int p = 0; p < NUM_RD; p++) begin
            checks++;
            if (read_data[p*XLEN +: XLEN] !== e.data[p]) begin
               errors++;
               $display("FAIL read_data%0d cyc %0d got %h exp %h",
                        p, e.cyc, read_data[p*XLEN +: XLEN], e.data[p]);
            end
            checks++;
            if (read_pending[p] !== e.pend[p]) begin
               errors++;
               $display("FAIL read_pending%0d cyc %0d got %b exp %b",
                        p, e.cyc, read_pending[p], e.pend[p]);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog timeout at cyc %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin : drive
      int wa, ir, ra0, ra1;
      foreach (m_reg[k])  m_reg[k]  = '0;
      foreach (m_pend[k]) m_pend[k] = 1'b0;
      rst = 1'b1;
      write_enable = 1'b0;
      write_register_addr = '0;
      write_data = '0;
      issue_valid = 1'b0;
      issue_rd = '0;
      read_register_addr = '0;

      // T1 reset clear
      step(1, 0, 0, '0, 0, 0, 0, 1);
      step(1, 0, 0, '0, 0, 0, 2, 3);
      for (int i = 0; i < DEPTH + 2; i++)
         idle($urandom_range(0, 31), $urandom_range(0, 31));
      for (int i = 0; i < DEPTH; i += 2) idle(i, i + 1);

      // T2 write/read, register 0
      step(0, 1, 5, 32'd6, 0, 0, 5, 5);
      idle(5, 5);
      step(0, 1, 0, 32'hDEAD, 0, 0, 0, 5);
      idle(0, 0);

      // T3 same-cycle read of written register
      step(0, 1, 7, 32'h1234, 0, 0, 7, 5);
      idle(7, 7);

      // T4 scoreboard
      step(0, 0, 0, '0, 1, 9, 9, 8);
      idle(9, 8);
      step(0, 1, 9, 32'h99, 0, 0, 9, 9);
      idle(9, 9);
      step(0, 0, 0, '0, 1, 9, 9, 9);
      step(0, 1, 9, 32'h77, 1, 9, 9, 9);
      idle(9, 9);
      step(0, 0, 0, '0, 1, 0, 0, 0);
      idle(0, 9);

      // Random traffic with occasional reset
      for (int i = 0; i < 800; i++) begin
         wa  = $urandom_range(0, 31);
         ir  = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
         ra0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
         ra1 = ($urandom_range(0, 2) == 0) ? ir : $urandom_range(0, 31);
         step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
              wa, $urandom, $urandom_range(0, 2) == 0, ir, ra0, ra1);
      end

      // T5 reset mid-operation, restarted at clr_cnt=10
      for (int i = 0; i < DEPTH + 2; i++) idle(0, 1);
      step(0, 1, 3, 32'hAA, 0, 0, 3, 3);
      idle(3, 3);
      step(0, 0, 0, '0, 1, 12, 3, 12);
      step(1, 0, 0, '0, 0, 0, 3, 3);
      for (int i = 0; i < 10; i++) idle(3, 12);
      step(1, 0, 0, '0, 0, 0, 3, 3);

      // T6 writes and issues held during CLEAR are ignored
      for (int i = 0; i < DEPTH + 2; i++) begin
         wa = $urandom_range(1, 31);
         step(0, 1, wa, $urandom, 1, wa, 3, wa);
      end
      for (int i = 0; i < DEPTH; i += 2) idle(i, i + 1);

      @(negedge clk);
      @(negedge clk);
      #5;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
